// File: rtl/bus_ram_responder_pkg.sv
// Shared definitions for the bus RAM responder: FSM state encodings,
// latency limits and the wait-counter load helper.
package bus_ram_responder_pkg;

    typedef enum logic [1:0] {
        BUS_RSP_IDLE = 2'd0,
        BUS_RSP_WAIT = 2'd1,
        BUS_RSP_DONE = 2'd2,
        BUS_RSP_TURN = 2'd3
    } bus_rsp_state_e;

    localparam int unsigned BUS_RSP_MAX_LATENCY = 32'd15;
    localparam int unsigned BUS_RSP_CNT_WIDTH   = 32'd4;

    // Counter load for a latency; out-of-range values are clamped to 1..15.
    function automatic logic [3:0] latency_load(input int unsigned latency);
        logic [3:0] load_v;
        if (latency == 32'd0) begin
            load_v = 4'd0;
        end else if (latency > BUS_RSP_MAX_LATENCY) begin
            load_v = 4'(BUS_RSP_MAX_LATENCY - 32'd1);
        end else begin
            load_v = 4'(latency - 32'd1);
        end
        return load_v;
    endfunction

endpackage

// File: rtl/bus_ram_responder_if.sv
// Data-side request/ready bus between the data cache (master) and a
// memory responder (slave).
interface bus_ram_responder_if;
    logic        i_request;
    logic        i_rw;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic [31:0] o_rdata;

    modport master (
        output i_request, i_rw, i_address, i_wdata,
        input  o_ready, o_rdata
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata,
        output o_ready, o_rdata
    );
endinterface

// File: rtl/bus_ram_responder_array.sv
// Single-port synchronous word RAM with one write enable and a registered,
// enable-gated read port whose register holds between reads.
module bus_ram_array #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_r [0:(1 << ADDR_WIDTH) - 1];
    logic [31:0] rdata_r;

    // Storage write port; left without reset so contents survive reset.
    always_ff @(posedge i_clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register, cleared by reset and loaded only on a read commit.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rdata_r <= 32'd0;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/bus_ram_responder.sv
// RAM target for the CPU data bus: handshake FSM with programmable read and
// write wait states in front of a single-port word array.
module bus_ram_responder
    import bus_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 12,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    bus_ram_responder_if.slave  bus
);

    localparam logic [3:0] RD_LOAD = latency_load(READ_LATENCY);
    localparam logic [3:0] WR_LOAD = latency_load(WRITE_LATENCY);

    bus_rsp_state_e        state_r, state_s;
    logic [3:0]            cnt_r, cnt_s;
    logic                  rw_r, rw_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_s;
    logic [31:0]           wdata_r, wdata_s;
    logic                  ready_r, ready_s;

    logic [ADDR_WIDTH-1:0] in_idx_s;
    logic [3:0]            load_s;
    logic                  we_s;
    logic                  re_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [31:0]           mem_wdata_s;
    logic [31:0]           mem_rdata_s;
    logic                  addr_unused_s;

    assign in_idx_s      = bus.i_address[ADDR_WIDTH+1:2];
    assign addr_unused_s = ^{bus.i_address[31:ADDR_WIDTH+2], bus.i_address[1:0]};
    assign load_s        = bus.i_rw ? WR_LOAD : RD_LOAD;

    // Next state, capture and commit strobes; the counter holds cycles left until ready.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        rw_s        = rw_r;
        idx_s       = idx_r;
        wdata_s     = wdata_r;
        ready_s     = 1'b0;
        we_s        = 1'b0;
        re_s        = 1'b0;
        mem_addr_s  = idx_r;
        mem_wdata_s = wdata_r;
        case (state_r)
            BUS_RSP_IDLE: begin
                // A latency of one commits straight from the accepting edge.
                mem_addr_s  = in_idx_s;
                mem_wdata_s = bus.i_wdata;
                if (bus.i_request) begin
                    rw_s    = bus.i_rw;
                    idx_s   = in_idx_s;
                    wdata_s = bus.i_wdata;
                    cnt_s   = load_s;
                    if (load_s == 4'd0) begin
                        state_s = BUS_RSP_DONE;
                        ready_s = 1'b1;
                        we_s    = bus.i_rw;
                        re_s    = ~bus.i_rw;
                    end else begin
                        state_s = BUS_RSP_WAIT;
                    end
                end else begin
                    state_s = BUS_RSP_IDLE;
                end
            end
            BUS_RSP_WAIT: begin
                if (!bus.i_request) begin
                    state_s = BUS_RSP_IDLE;
                    cnt_s   = 4'd0;
                end else if (cnt_r <= 4'd1) begin
                    state_s = BUS_RSP_DONE;
                    cnt_s   = 4'd0;
                    ready_s = 1'b1;
                    we_s    = rw_r;
                    re_s    = ~rw_r;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            BUS_RSP_DONE: begin
                state_s = BUS_RSP_TURN;
            end
            BUS_RSP_TURN: begin
                state_s = BUS_RSP_IDLE;
            end
            default: begin
                state_s = BUS_RSP_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM, counter, capture and ready registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= BUS_RSP_IDLE;
            cnt_r   <= 4'd0;
            rw_r    <= 1'b0;
            idx_r   <= '0;
            wdata_r <= 32'd0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rw_r    <= rw_s;
            idx_r   <= idx_s;
            wdata_r <= wdata_s;
            ready_r <= ready_s;
        end
    end

    bus_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .we      (we_s),
        .re      (re_s),
        .addr    (mem_addr_s),
        .wdata   (mem_wdata_s),
        .rdata   (mem_rdata_s)
    );

    assign bus.o_ready = ready_r;
    assign bus.o_rdata = mem_rdata_s;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Scoreboard bench for bus_ram_responder: two instances with different
// latencies, directed scenarios followed by randomized traffic.
module tb_bus_ram_responder;

    localparam int AW   = 12;
    localparam int RL_A = 2;
    localparam int WL_A = 1;
    localparam int RL_B = 4;
    localparam int WL_B = 3;

    typedef struct {
        int          at;
        logic [31:0] data;
        bit          rw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] model_mem [int];
    logic [31:0] last_rd  [2];
    int          free_at  [2];
    int          raise_at [2];

    bus_ram_responder_if bus_a ();
    bus_ram_responder_if bus_b ();

    bus_ram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL_A), .WRITE_LATENCY(WL_A)) u_dut_a (
        .i_clock (clk),
        .i_reset (rst_a_n),
        .bus     (bus_a)
    );

    bus_ram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL_B), .WRITE_LATENCY(WL_B)) u_dut_b (
        .i_clock (clk),
        .i_reset (rst_b_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d, input bit rw);
        if (d == 0) return rw ? WL_A : RL_A;
        return rw ? WL_B : RL_B;
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s at cycle %0d: got 0x%h expected 0x%h", d, name, cyc, act, exp);
        end
    endtask

    task automatic set_bus(input int d, input bit req, input bit rw, input logic [31:0] addr, input logic [31:0] wd);
        if (d == 0) begin
            bus_a.i_request = req; bus_a.i_rw = rw; bus_a.i_address = addr; bus_a.i_wdata = wd;
        end else begin
            bus_b.i_request = req; bus_b.i_rw = rw; bus_b.i_address = addr; bus_b.i_wdata = wd;
        end
    endtask

    task automatic set_req(input int d, input bit req);
        if (d == 0) bus_a.i_request = req;
        else        bus_b.i_request = req;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Complete transaction: request rises at the earliest legal point and is kept
    // until the completion pulse has been seen; returns in the turnaround cycle.
    task automatic issue(input int d, input bit rw, input logic [31:0] addr, input logic [31:0] wd, input bit scramble);
        int   acc;
        int   rdy;
        int   key;
        exp_t e;
        goto(raise_at[d]);
        set_bus(d, 1'b1, rw, addr, wd);
        acc  = (cyc > free_at[d]) ? cyc : free_at[d];
        rdy  = acc + lat_of(d, rw);
        key  = d * 65536 + int'(addr[AW+1:2]);
        e.at = rdy;
        e.rw = rw;
        if (rw) begin
            model_mem[key] = wd;
            e.data = last_rd[d];
        end else begin
            e.data = model_mem.exists(key) ? model_mem[key] : 32'h0;
            last_rd[d] = e.data;
        end
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
        free_at[d]  = rdy + 2;
        raise_at[d] = rdy + 1;
        if (scramble) begin
            goto(acc + 1);
            set_bus(d, 1'b1, rw, addr + 32'd4, 32'd0);
        end
        goto(rdy + 1);
        set_req(d, 1'b0);
    endtask

    // Request accepted from IDLE and withdrawn after 'hold' cycles, before completion.
    task automatic abort_xact(input int d, input bit rw, input logic [31:0] addr, input logic [31:0] wd, input int hold);
        int n;
        goto(free_at[d]);
        n = cyc;
        set_bus(d, 1'b1, rw, addr, wd);
        goto(n + hold);
        set_req(d, 1'b0);
        free_at[d]  = n + hold + 1;
        raise_at[d] = n + hold + 1;
    endtask

    task automatic mon(input int d);
        logic        rdy;
        logic [31:0] rd;
        int          n;
        exp_t        e;
        if (d == 0) begin
            rdy = bus_a.o_ready; rd = bus_a.o_rdata; n = qa.size();
            if (n > 0) e = qa[0];
        end else begin
            rdy = bus_b.o_ready; rd = bus_b.o_rdata; n = qb.size();
            if (n > 0) e = qb[0];
        end
        if (rdy !== 1'b0) begin
            if (n == 0) begin
                chk(d, "spurious_ready", rdy, 1'b0);
            end else begin
                if (d == 0) void'(qa.pop_front());
                else        void'(qb.pop_front());
                chk(d, "ready_cycle", 32'(cyc), 32'(e.at));
                chk(d, e.rw ? "rdata_after_write" : "rdata_read", rd, e.data);
            end
        end else if (n > 0 && cyc > e.at) begin
            chk(d, "missing_ready", rdy, 1'b1);
            if (d == 0) void'(qa.pop_front());
            else        void'(qb.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_bus(1, 1'b0, 1'b0, 32'd0, 32'd0);
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk(0, "reset_ready", bus_a.o_ready, 32'd0);
        chk(0, "reset_rdata", bus_a.o_rdata, 32'd0);
        chk(1, "reset_ready", bus_b.o_ready, 32'd0);
        chk(1, "reset_rdata", bus_b.o_rdata, 32'd0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(posedge clk);
        #1;
        free_at[0] = cyc; free_at[1] = cyc;
        raise_at[0] = cyc; raise_at[1] = cyc;

        // Default latencies, byte-offset addressing and aliasing
        issue(0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1'b0);
        issue(0, 1'b0, 32'h0000_0107, 32'h0, 1'b0);
        issue(0, 1'b1, 32'h0000_4008, 32'h1234_5678, 1'b0);
        issue(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0);

        // Back-to-back with request continuously high
        issue(0, 1'b1, 32'h0, 32'd1, 1'b0);
        issue(0, 1'b1, 32'h4, 32'd2, 1'b0);
        issue(0, 1'b1, 32'h8, 32'd3, 1'b0);
        issue(0, 1'b0, 32'h0, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h4, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h8, 32'h0, 1'b0);

        // Aborted reads keep o_rdata; the next request is taken right after
        issue(1, 1'b1, 32'h10, 32'h5A5A_0F0F, 1'b0);
        issue(1, 1'b1, 32'h14, 32'h0123_4567, 1'b0);
        issue(1, 1'b0, 32'h14, 32'h0, 1'b0);
        abort_xact(1, 1'b0, 32'h10, 32'h0, 2);
        goto(cyc + 4);
        chk(1, "abort_rdata_hold", bus_b.o_rdata, last_rd[1]);
        abort_xact(1, 1'b0, 32'h10, 32'h0, 2);
        issue(1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Reset in the second WAIT cycle of a write: no commit, no ready
        issue(1, 1'b1, 32'h40, 32'h1111_1111, 1'b0);
        goto(free_at[1]);
        n = cyc;
        set_bus(1, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        goto(n + 2);
        rst_b_n = 1'b0;
        #1;
        chk(1, "midreset_ready", bus_b.o_ready, 32'd0);
        chk(1, "midreset_rdata", bus_b.o_rdata, 32'd0);
        set_req(1, 1'b0);
        @(posedge clk);
        #1;
        rst_b_n = 1'b1;
        last_rd[1]  = 32'd0;
        free_at[1]  = cyc + 1;
        raise_at[1] = cyc + 1;
        goto(cyc + 4);
        issue(1, 1'b0, 32'h40, 32'h0, 1'b0);

        // Address and data changed after accept are ignored
        issue(1, 1'b1, 32'h24, 32'h0BAD_C0DE, 1'b0);
        issue(1, 1'b1, 32'h20, 32'hAAAA_5555, 1'b1);
        issue(1, 1'b0, 32'h20, 32'h0, 1'b0);
        issue(1, 1'b0, 32'h24, 32'h0, 1'b0);

        // Random traffic over a preloaded pool of words, with aliased addresses
        for (int i = 0; i < 8; i++) begin
            issue(0, 1'b1, 32'(48 + i) << 2, $urandom, 1'b0);
            issue(1, 1'b1, 32'(48 + i) << 2, $urandom, 1'b0);
        end
        for (int it = 0; it < 160; it++) begin
            int          d;
            int          k;
            int          g;
            bit          rw;
            bit          scr;
            logic [31:0] a;
            logic [31:0] wd;
            d   = int'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            a   = ($urandom & 32'hFFFF_C000) | (32'(48 + k) << 2) | 32'($urandom_range(0, 3));
            wd  = $urandom;
            scr = ($urandom_range(0, 3) == 0);
            g   = int'($urandom_range(0, 2));
            goto(cyc + g);
            if ($urandom_range(0, 7) == 0 && lat_of(d, rw) > 1)
                abort_xact(d, rw, a, wd, int'($urandom_range(1, lat_of(d, rw) - 1)));
            else
                issue(d, rw, a, wd, scr);
        end

        goto(cyc + 8);
        chk(0, "queue_drained", 32'(qa.size()), 32'd0);
        chk(1, "queue_drained", 32'(qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
